simd_regfile_sb: RTL

SIMD_REGFILE_SB -- requirements
Module: simd_regfile_sb

---
 rtl/simd_regfile_sb.sv | 110 +++++++++++
 1 files changed

// File: rtl/simd_regfile_sb.sv
// SIMD register file with a write scoreboard and a registered operand bundle for execute.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to operand reads.
module simd_regfile_sb #(
  parameter int DATA_W   = 128,
  parameter int NUM_REGS = 32,
  parameter int INSTR_W  = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_instr,
  output logic               id_ready,
  output logic               exe_valid,
  input  logic               exe_ready,
  output logic [INSTR_W-1:0] exe_instr,
  output logic [DATA_W-1:0]  rs1_data,
  output logic [DATA_W-1:0]  rs2_data,
  output logic [DATA_W-1:0]  rs3_data,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wb_valid,
  input  logic [INSTR_W-1:0] wb_instr,
  input  logic [DATA_W-1:0]  wb_data
);

  localparam int AW = $clog2(NUM_REGS);

  // Opcode class 3 with a zero rs3 field produces no register result.
  function automatic logic writes_dest(input logic [INSTR_W-1:0] instr);
    return (instr != '0) &&
           !((instr[INSTR_W-1:INSTR_W-2] == 2'b11) && (instr[AW+14:15] == '0));
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic                wb_write;
  logic [AW-1:0]       wb_rd;
  logic [AW-1:0]       src_idx [4];
  logic [DATA_W-1:0]   operand [4];
  logic [3:0]          src_haz;
  logic                hazard;
  logic                accept;

  assign wb_write   = wb_valid && writes_dest(wb_instr);
  assign wb_rd      = wb_instr[AW-1:0];

  assign src_idx[0] = id_instr[AW+4:5];
  assign src_idx[1] = id_instr[AW+9:10];
  assign src_idx[2] = id_instr[AW+14:15];
  assign src_idx[3] = id_instr[AW-1:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
`ifdef REGFILE_BYPASS_EN
      logic wb_hit;
      assign wb_hit       = wb_write && (wb_rd == src_idx[gi]);
      assign src_haz[gi]  = busy_reg[src_idx[gi]] && !wb_hit;
      assign operand[gi]  = wb_hit ? wb_data : regs[src_idx[gi]];
`else
      assign src_haz[gi]  = busy_reg[src_idx[gi]];
      assign operand[gi]  = regs[src_idx[gi]];
`endif
    end
  endgenerate

  assign hazard   = |src_haz;
  assign id_ready = !hazard && (!exe_valid || exe_ready);
  assign accept   = id_valid && id_ready;

  // Issue-side set is applied after the writeback clear so it wins on the same index.
  always_comb begin
    busy_next = busy_reg;
    if (wb_write) busy_next[wb_rd] = 1'b0;
    if (accept && writes_dest(id_instr)) busy_next[src_idx[3]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid <= 1'b0;
      exe_instr <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      rs3_data  <= '0;
      rd_data   <= '0;
    end else if (accept) begin
      exe_valid <= 1'b1;
      exe_instr <= id_instr;
      rs1_data  <= operand[0];
      rs2_data  <= operand[1];
      rs3_data  <= operand[2];
      rd_data   <= operand[3];
    end else if (exe_ready) begin
      exe_valid <= 1'b0;
    end
  end

endmodule
